// File: rtl/bounce_gen_pkg.sv
// Shared types and constants for the bounce_gen contact-bounce emulator.
// Holds the FSM state enum, LFSR taps/default seed and the counter width.
package bounce_gen_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BOUNCE,
    ST_SETTLE
  } state_t;

  localparam int          CNT_W             = 16;
  // Taps for x^16 + x^14 + x^13 + x^11 + 1 (bits 15, 13, 12, 10)
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

  // An all-zero seed would lock the LFSR, so it is swapped for the default
  function automatic logic [15:0] lfsr_fix(input logic [15:0] s);
    return (s == 16'h0000) ? LFSR_SEED_DEFAULT : s;
  endfunction

  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/bounce_gen_lfsr.sv
// 16-bit Fibonacci LFSR for randomised bounce gaps; only built when
// BOUNCE_GEN_LFSR_EN is defined.
`ifdef BOUNCE_GEN_LFSR_EN
module bounce_lfsr
  import bounce_gen_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] seed,
  input  logic        step,
  output logic [15:0] value
);

  logic [15:0] cur;

  // A load in the same cycle as a step advances from the freshly loaded seed
  assign cur = load ? lfsr_fix(seed) : value;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= LFSR_SEED_DEFAULT;
    end else if (load || step) begin
      value <= step ? lfsr_next(cur) : cur;
    end
  end

endmodule
`endif

// File: rtl/bounce_gen.sv
// Mechanical contact bounce emulator: turns a clean level into a burst of
// glitches followed by a settle period. Macro BOUNCE_GEN_LFSR_EN randomises gaps.
module bounce_gen
  import bounce_gen_pkg::*;
#(
  parameter int GAP_MIN    = 20,
  parameter int GAP_MASK   = 31,
  parameter int BOUNCES    = 2,
  parameter int SETTLE_CYC = 2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        level_in,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic        button,
  output logic        busy,
  output logic        done
);

  localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);
  localparam logic [CNT_W-1:0] GAP_BASE   = (GAP_MIN == 0) ? ONE : CNT_W'(GAP_MIN);
  localparam logic [CNT_W-1:0] SETTLE_LEN = (SETTLE_CYC == 0) ? ONE : CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] REM_INIT   = CNT_W'(2 * BOUNCES);
  localparam logic [CNT_W-1:0] MASK       = CNT_W'(GAP_MASK);

  state_t           state, state_d;
  logic [CNT_W-1:0] cnt, cnt_d;
  logic [CNT_W-1:0] rem, rem_d;
  logic             target, target_d;
  logic             button_d, done_d;
  logic [CNT_W-1:0] gap;
  logic             gap_step;

`ifdef BOUNCE_GEN_LFSR_EN
  logic        lfsr_load;
  logic [15:0] lfsr_value;
  logic [15:0] gap_src;

  // Seed strobes only count in IDLE; a coincident load feeds the first gap
  assign lfsr_load = seed_load && (state == ST_IDLE);
  assign gap_src   = lfsr_load ? lfsr_fix(seed) : lfsr_value;
  assign gap       = GAP_BASE + (gap_src & MASK);

  bounce_lfsr u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .load  (lfsr_load),
    .seed  (seed),
    .step  (gap_step),
    .value (lfsr_value)
  );
`else
  logic unused_lfsr_inputs;
  assign unused_lfsr_inputs = ^{seed_load, seed, gap_step, MASK};
  assign gap = GAP_BASE;
`endif

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      rem    <= '0;
      target <= 1'b0;
      button <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      rem    <= rem_d;
      target <= target_d;
      button <= button_d;
      done   <= done_d;
    end
  end

  // cnt counts down to the next toggle in BOUNCE and to the done pulse in SETTLE
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    rem_d    = rem;
    target_d = target;
    button_d = button;
    done_d   = 1'b0;
    gap_step = 1'b0;
    case (state)
      ST_IDLE: begin
        if (level_in != button) begin
          target_d = level_in;
          button_d = ~button;
          if (BOUNCES == 0) begin
            state_d = ST_SETTLE;
            cnt_d   = SETTLE_LEN;
          end else begin
            state_d  = ST_BOUNCE;
            cnt_d    = gap;
            gap_step = 1'b1;
            rem_d    = REM_INIT;
          end
        end
      end
      ST_BOUNCE: begin
        if (cnt == ONE) begin
          rem_d = rem - ONE;
          if (rem == ONE) begin
            button_d = target;
            state_d  = ST_SETTLE;
            cnt_d    = SETTLE_LEN;
          end else begin
            button_d = ~button;
            cnt_d    = gap;
            gap_step = 1'b1;
          end
        end else begin
          cnt_d = cnt - ONE;
        end
      end
      ST_SETTLE: begin
        if (cnt == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d  = cnt - ONE;
          done_d = (cnt == ONE);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bounce_gen.sv
// Self-checking bench for bounce_gen: directed vector table for exact timing
// plus hand-written sequences for seeding, reset abort and BOUNCES=0.
module tb_bounce_gen;

`ifdef BOUNCE_GEN_LFSR_EN
  localparam int EXP_FIRST = 21;
  localparam int GAP_HI    = 51;
`else
  localparam int EXP_FIRST = 20;
  localparam int GAP_HI    = 20;
`endif

  logic        clk;
  logic        rst;
  logic        level_a, level_b;
  logic        seed_load;
  logic [15:0] seed;
  logic        button_a, busy_a, done_a;
  logic        button_b, busy_b, done_b;

  int vec_count  = 0;
  int miss_count = 0;

  bounce_gen dut (
    .clk       (clk),
    .rst       (rst),
    .level_in  (level_a),
    .seed_load (seed_load),
    .seed      (seed),
    .button    (button_a),
    .busy      (busy_a),
    .done      (done_a)
  );

  bounce_gen #(.BOUNCES(0)) dut0 (
    .clk       (clk),
    .rst       (rst),
    .level_in  (level_b),
    .seed_load (seed_load),
    .seed      (seed),
    .button    (button_b),
    .busy      (busy_b),
    .done      (done_b)
  );

  // 20 ns clock
  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    vec_count++;
    if (actual !== expected) begin
      miss_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic lvl, input int cycles);
    level_a = lvl;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  task automatic waitIdleA();
    bit ok = 1'b0;
    for (int c = 0; c < 3000 && !ok; c++) begin
      @(posedge clk); #1;
      if (!busy_a) ok = 1'b1;
    end
    checkOutput("idle_wait", 32'(ok), 32'd1);
  endtask

  // Follows one burst on dut after level_a was changed; measures toggles, gaps and settle
  task automatic measureBurst(input logic target, input string tag);
    int toggles = 0, first_gap = 0, gmin = 1000000, gmax = 0, last_c = 0;
    int dones = 0, settle = 0, gap;
    logic prev = button_a;
    bit finished = 1'b0;
    for (int c = 1; c <= 4000 && !finished; c++) begin
      @(posedge clk); #1;
      seed_load = 1'b0;
      if (button_a !== prev) begin
        toggles++;
        if (toggles > 1) begin
          gap = c - last_c;
          if (toggles == 2) first_gap = gap;
          if (gap < gmin) gmin = gap;
          if (gap > gmax) gmax = gap;
        end
        last_c = c;
        prev   = button_a;
      end
      if (done_a) begin
        dones++;
        settle = c - last_c;
      end
      if (!busy_a) finished = 1'b1;
    end
    checkOutput({tag, "_finished"}, 32'(finished), 32'd1);
    checkOutput({tag, "_toggles"}, 32'(toggles), 32'd5);
    checkOutput({tag, "_end_button"}, 32'(button_a), 32'(target));
    checkOutput({tag, "_done_pulses"}, 32'(dones), 32'd1);
    checkOutput({tag, "_settle"}, 32'(settle), 32'd2000);
    checkOutput({tag, "_first_gap"}, 32'(first_gap), 32'(EXP_FIRST));
    checkOutput({tag, "_gap_min_ok"}, 32'(gmin >= 20), 32'd1);
    checkOutput({tag, "_gap_max_ok"}, 32'(gmax <= GAP_HI), 32'd1);
  endtask

`ifndef BOUNCE_GEN_LFSR_EN
  typedef struct {
    logic lvl;
    int   cyc;
    logic btn;
    logic bsy;
    logic dn;
  } vec_t;
  vec_t vecs[20];
`endif

  initial begin
    int   t;
    bit   done_seen;
    int   busy_cnt, done_cnt, tog_cnt;
    logic prev;

    rst = 1'b0; level_a = 1'b0; level_b = 1'b0; seed_load = 1'b0; seed = 16'h0000;
    #25;
    checkOutput("reset_button", 32'(button_a), 32'd0);
    checkOutput("reset_busy", 32'(busy_a), 32'd0);
    checkOutput("reset_done", 32'(done_a), 32'd0);
    checkOutput("reset_button_b", 32'(button_b), 32'd0);
    checkOutput("reset_busy_b", 32'(busy_b), 32'd0);
    @(negedge clk);
    rst = 1'b1;

`ifndef BOUNCE_GEN_LFSR_EN
    // Burst 0->1: toggles at edges 1,21,41,61,81; done at 2081; idle at 2082
    vecs[0]  = '{1'b1, 1,    1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 19,   1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 1,    1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 19,   1'b0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 1,    1'b1, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 20,   1'b0, 1'b1, 1'b0};
    vecs[6]  = '{1'b1, 20,   1'b1, 1'b1, 1'b0};
    vecs[7]  = '{1'b1, 1999, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1,    1'b1, 1'b1, 1'b1};
    vecs[9]  = '{1'b1, 1,    1'b1, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 5,    1'b1, 1'b0, 1'b0};
    // Burst 1->0 with level_in flipped back mid-burst: completes to 0, restarts after
    vecs[11] = '{1'b0, 1,    1'b0, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 1,    1'b0, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 19,   1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 20,   1'b0, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 20,   1'b1, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 20,   1'b0, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 2000, 1'b0, 1'b1, 1'b1};
    vecs[18] = '{1'b1, 1,    1'b0, 1'b0, 1'b0};
    vecs[19] = '{1'b1, 1,    1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].lvl, vecs[i].cyc);
      checkOutput($sformatf("vec%0d_button", i), 32'(button_a), 32'(vecs[i].btn));
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy_a), 32'(vecs[i].bsy));
      checkOutput($sformatf("vec%0d_done", i), 32'(done_a), 32'(vecs[i].dn));
    end
    waitIdleA();
`else
    level_a = 1'b1;
    measureBurst(1'b1, "rand_up");
    seed_load = 1'b1; seed = 16'h0000;
    @(posedge clk); #1;
    seed_load = 1'b0;
    checkOutput("seed_zero_fix", 32'(dut.u_lfsr.value), 32'h0000ACE1);
`endif

    // Seed strobe coinciding with a mismatch: zero seed becomes ACE1 before first gap
    level_a = 1'b0; seed_load = 1'b1; seed = 16'h0000;
    measureBurst(1'b0, "seeded_down");

    // Reset during SETTLE aborts with no done pulse
    level_a = 1'b1;
    t = 0;
    done_seen = 1'b0;
    prev = button_a;
    for (int c = 0; c < 1000 && t < 5; c++) begin
      @(posedge clk); #1;
      if (button_a !== prev) begin t++; prev = button_a; end
    end
    checkOutput("pre_reset_toggles", 32'(t), 32'd5);
    repeat (100) begin
      @(posedge clk); #1;
      done_seen |= done_a;
    end
    #5 rst = 1'b0;
    #1;
    checkOutput("abort_button", 32'(button_a), 32'd0);
    checkOutput("abort_busy", 32'(busy_a), 32'd0);
    repeat (3) begin
      @(posedge clk); #1;
      done_seen |= done_a;
    end
    checkOutput("abort_no_done", 32'(done_seen), 32'd0);
    rst = 1'b1;
    measureBurst(1'b1, "post_reset");

    // BOUNCES=0 instance: single clean toggle, 2001 busy cycles, one done
    level_b = 1'b1;
    @(posedge clk); #1;
    checkOutput("b0_rise_button", 32'(button_b), 32'd1);
    checkOutput("b0_rise_busy", 32'(busy_b), 32'd1);
    t = 0;
    for (int c = 0; c < 3000 && busy_b; c++) begin
      @(posedge clk); #1;
      t++;
    end
    checkOutput("b0_idle", 32'(busy_b), 32'd0);
    level_b = 1'b0;
    busy_cnt = 0; done_cnt = 0; tog_cnt = 0;
    prev = button_b;
    @(posedge clk); #1;
    checkOutput("b0_fall_latency", 32'(button_b), 32'd0);
    for (int c = 0; c < 3000; c++) begin
      if (busy_b) busy_cnt++;
      if (done_b) done_cnt++;
      if (button_b !== prev) begin tog_cnt++; prev = button_b; end
      if (!busy_b) break;
      @(posedge clk); #1;
    end
    checkOutput("b0_busy_cycles", 32'(busy_cnt), 32'd2001);
    checkOutput("b0_done_pulses", 32'(done_cnt), 32'd1);
    checkOutput("b0_toggles", 32'(tog_cnt), 32'd1);
    checkOutput("b0_end_button", 32'(button_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 SHALL have parameter GAP_MIN, default 20: minimum cycles between successive output toggles during a bounce burst.
REQ-002 SHALL have parameter GAP_MASK, default 31: mask applied to LFSR value, added to GAP_MIN.
REQ-003 SHALL have parameter BOUNCES, default 2: number of glitch pairs before the final transition (0 = clean edge).
REQ-004 SHALL have parameter SETTLE_CYC, default 2000: cycles the output is held stable after the final transition.
REQ-005 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port level_in  input  1  clean target contact level.
REQ-008 SHALL have port seed_load  input  1  one-cycle strobe loading seed into LFSR (IDLE only).
REQ-009 SHALL have port seed  input  16  LFSR seed value.
REQ-010 SHALL have port button  output  1  emulated bouncing contact, registered.
REQ-011 SHALL have port busy  output  1  high in BOUNCE and SETTLE.
REQ-012 SHALL have port done  output  1  one-cycle pulse at end of SETTLE.

Function
REQ-013 SHALL implement FSM states IDLE, BOUNCE, SETTLE.
REQ-014 IDLE: when level_in != button, SHALL latch target=level_in, toggle button on the same edge that enters BOUNCE (1-cycle latency from sampled level_in), and load gap counter.
REQ-015 BOUNCE: SHALL toggle button each time gap counter expires; total toggles per burst = 2*BOUNCES+1, so button ends equal to target.
REQ-016 Gap length SHALL be GAP_MIN + (lfsr[15:0] & GAP_MASK) cycles, computed in 16-bit unsigned arithmetic; LFSR advances once per gap load.
REQ-017 After the final toggle SHALL enter SETTLE, hold button constant SETTLE_CYC cycles, pulse done for 1 cycle, return to IDLE.
REQ-018 level_in changes during BOUNCE/SETTLE SHALL be ignored; the mismatch is re-evaluated in IDLE on the cycle after return.
REQ-019 BOUNCES=0 SHALL produce a single clean toggle followed by SETTLE.
REQ-020 LFSR SHALL be 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1; seed 16'h0000 SHALL be replaced by 16'hACE1.
REQ-021 seed_load outside IDLE SHALL be ignored; seed_load coinciding with a level mismatch in IDLE SHALL load the seed before the first gap is computed.
REQ-022 GAP_MIN=0 SHALL be treated as 1 (no zero-length gaps).

Reset
REQ-023 On rst low SHALL asynchronously force state=IDLE, button=0, busy=0, done=0, counters=0, LFSR=16'hACE1.
REQ-024 Reset mid-burst SHALL abort the burst with no done pulse; after release, level_in=1 starts a new burst from button=0.

Configuration
REQ-025 Macro BOUNCE_GEN_LFSR_EN defined: gaps randomised per REQ-016.
REQ-026 Macro undefined: LFSR and seed logic SHALL be omitted, every gap SHALL be exactly GAP_MIN cycles, seed/seed_load SHALL be ignored.

Structure
REQ-027 Package bounce_gen_pkg SHALL hold the state enum, LFSR tap constants, default seed 16'hACE1, and 16-bit counter width constant.
REQ-028 LFSR SHALL be a sub-module bounce_lfsr (ports clk, rst, load, seed, step, value).

Verification
REQ-029 Macro off, GAP_MIN=20, BOUNCES=2: level_in 0->1 -> button toggles 5 times at 20-cycle spacing, ends 1, done 2000 cycles after last toggle.
REQ-030 Macro on, seed=16'h0000 loaded -> LFSR value 16'hACE1; all gaps in [20,51] cycles; burst ends with button=level_in.
REQ-031 BOUNCES=0: level_in 1->0 -> single toggle 1 cycle later, busy high 2001 cycles, one done pulse.
REQ-032 level_in toggled back mid-BOUNCE -> burst completes to original target; new burst starts 1 cycle after done.
REQ-033 rst asserted during SETTLE -> button=0, busy=0 immediately, no done pulse.
REQ-034 Chain with existing debounce block (default bench timing, 20 ns clk): each burst yields exactly one clean transition on its result output.
